// File: rtl/lane_occupancy_tracker.sv
// Per-lane car queue counters: arrivals from sensor pulses, departures paced by
// a startup/flow timer while the lane shows green. Outputs are all registered.
//
// state   | meaning
// IDLE    | lane red, timer held at 0
// STARTUP | green, paying startup loss before the first departure window
// FLOW    | green, one departure window every DEPART_CYCLES cycles
module lane_occupancy_tracker #(
    parameter int NUM_LANES     = 8,
    parameter int COUNT_W       = 8,
    parameter int START_DELAY   = 2,
    parameter int DEPART_CYCLES = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_LANES-1:0]              arrive,
    input  logic [NUM_LANES-1:0]              green,
    output logic [NUM_LANES-1:0][COUNT_W-1:0] lane,
    output logic [NUM_LANES-1:0]              depart,
    output logic [NUM_LANES-1:0]              overflow
);

    localparam int MAX_T = (START_DELAY > DEPART_CYCLES) ? START_DELAY : DEPART_CYCLES;
    localparam int TW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [TW-1:0]      START_LAST  = TW'(START_DELAY - 1);
    localparam logic [TW-1:0]      DEPART_LAST = TW'(DEPART_CYCLES - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STARTUP = 2'd1,
        FLOW    = 2'd2
    } state_t;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        state_t             state_q, state_d;
        logic [TW-1:0]      t_q, t_d;
        logic [COUNT_W-1:0] cnt_q, cnt_d;
        logic               dep_q;
        logic               ovf_q, ovf_d;
        logic               fire;

        always_comb begin
            state_d = state_q;
            t_d     = '0;
            fire    = 1'b0;
            cnt_d   = cnt_q;
            ovf_d   = ovf_q;

            // Dropping green wins over every other transition.
            if (!green[i]) begin
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE: state_d = STARTUP;
                    STARTUP: begin
                        if (t_q == START_LAST) state_d = FLOW;
                        else                   t_d = t_q + 1'b1;
                    end
                    FLOW: begin
                        if (t_q == DEPART_LAST) fire = (cnt_q != '0);
                        else                    t_d = t_q + 1'b1;
                    end
                    default: state_d = IDLE;
                endcase
            end

            // A coincident arrival and departure cancel, so a full lane never overflows then.
            if (arrive[i] && !fire) begin
                if (cnt_q == CNT_MAX) ovf_d = 1'b1;
                else                  cnt_d = cnt_q + 1'b1;
            end else if (fire && !arrive[i]) begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= IDLE;
                t_q     <= '0;
                cnt_q   <= '0;
                dep_q   <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                t_q     <= t_d;
                cnt_q   <= cnt_d;
                dep_q   <= fire;
                ovf_q   <= ovf_d;
            end
        end

        assign lane[i]     = cnt_q;
        assign depart[i]   = dep_q;
        assign overflow[i] = ovf_q;
    end

endmodule

// File: tb/tb_lane_occupancy_tracker.sv
// Bench for lane_occupancy_tracker: directed scenarios plus random traffic,
// checked every cycle against a green-run-length queue model.
module tb_lane_occupancy_tracker;

    localparam int SD = 2;
    localparam int DC = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      arrive = '0;
    logic [7:0]      green = '0;
    logic [7:0][7:0] lane;
    logic [7:0]      depart;
    logic [7:0]      overflow;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    int exp_cnt [8];
    bit exp_dep [8];
    bit exp_ovf [8];
    int run     [8];

    lane_occupancy_tracker #(
        .NUM_LANES(8), .COUNT_W(8), .START_DELAY(SD), .DEPART_CYCLES(DC)
    ) dut (
        .clk(clk), .rst(rst), .arrive(arrive), .green(green),
        .lane(lane), .depart(depart), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Model: a lane that has seen green on n consecutive edges releases a car on
    // edge n = 1+SD+DC and every DC edges after that, provided a car is waiting.
    task automatic model_step();
        for (int i = 0; i < 8; i++) begin
            bit f;
            if (rst) begin
                exp_cnt[i] = 0; exp_dep[i] = 0; exp_ovf[i] = 0; run[i] = 0;
            end else begin
                run[i] = green[i] ? run[i] + 1 : 0;
                f = (run[i] >= 1 + SD + DC) && (((run[i] - 1 - SD) % DC) == 0)
                    && (exp_cnt[i] != 0);
                exp_dep[i] = f;
                if (arrive[i] && !f) begin
                    if (exp_cnt[i] == 255) exp_ovf[i] = 1;
                    else                   exp_cnt[i]++;
                end else if (f && !arrive[i]) begin
                    exp_cnt[i]--;
                end
            end
        end
    endtask

    task automatic cyc(input logic [7:0] a, input logic [7:0] g, input logic r);
        @(negedge clk);
        arrive = a; green = g; rst = r;
        model_step();
        if (r) chk_en = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (lane[i] != 8'(exp_cnt[i]) || depart[i] != exp_dep[i]
                    || overflow[i] != exp_ovf[i]) begin
                    n_errors++;
                    $display("FAIL cmp lane%0d t=%0t got cnt=%0d dep=%0b ovf=%0b want cnt=%0d dep=%0b ovf=%0b",
                             i, $time, lane[i], depart[i], overflow[i],
                             exp_cnt[i], exp_dep[i], exp_ovf[i]);
                end
            end
        end
    end

    initial begin
        // 1: reset with arrivals asserted
        cyc(8'hFF, 8'h00, 1'b1);
        cyc(8'hFF, 8'h00, 1'b1);
        cyc(8'h00, 8'h00, 1'b0);
        chk("rst_lane2", int'(lane[2]), 0);
        chk("rst_ovf", int'(overflow), 0);

        // 2: three arrivals on lane 2, no green
        repeat (3) begin cyc(8'h04, 8'h00, 1'b0); cyc(8'h00, 8'h00, 1'b0); end
        repeat (5) cyc(8'h00, 8'h00, 1'b0);
        chk("hold_lane2", int'(lane[2]), 3);
        chk("model_hold", exp_cnt[2], 3);

        // 3: green pair 2/3 discharges lane 2 at E6, E10, E14
        repeat (6) cyc(8'h00, 8'h0C, 1'b0);
        chk("pre_e6", int'(lane[2]), 3);
        cyc(8'h00, 8'h0C, 1'b0);
        chk("e6_lane2", int'(lane[2]), 2);
        chk("e6_dep2", int'(depart[2]), 1);
        chk("model_e6", exp_cnt[2], 2);
        repeat (4) cyc(8'h00, 8'h0C, 1'b0);
        chk("e10_lane2", int'(lane[2]), 1);
        repeat (4) cyc(8'h00, 8'h0C, 1'b0);
        chk("e14_lane2", int'(lane[2]), 0);
        chk("e14_lane3", int'(lane[3]), 0);
        repeat (5) cyc(8'h00, 8'h0C, 1'b0);
        chk("empty_nodep", int'(depart), 0);
        cyc(8'h00, 8'h00, 1'b0);

        // 4: arrival coincident with a departure holds the count
        repeat (5) cyc(8'h01, 8'h00, 1'b0);
        repeat (6) cyc(8'h00, 8'h01, 1'b0);
        cyc(8'h01, 8'h01, 1'b0);
        chk("coinc_lane0", int'(lane[0]), 5);
        chk("coinc_dep0", int'(depart[0]), 1);
        cyc(8'h00, 8'h00, 1'b0);

        // 5: saturation on lanes 4 and 5
        repeat (255) cyc(8'h30, 8'h00, 1'b0);
        chk("sat_lane4", int'(lane[4]), 255);
        chk("sat_noovf", int'(overflow[4]), 0);
        cyc(8'h10, 8'h00, 1'b0);
        chk("ovf_lane4", int'(lane[4]), 255);
        chk("ovf_set4", int'(overflow[4]), 1);
        repeat (3) cyc(8'h00, 8'h00, 1'b0);
        chk("ovf_sticky", int'(overflow[4]), 1);
        repeat (6) cyc(8'h00, 8'h20, 1'b0);
        cyc(8'h20, 8'h20, 1'b0);
        chk("satfire_lane5", int'(lane[5]), 255);
        chk("satfire_ovf5", int'(overflow[5]), 0);
        chk("satfire_dep5", int'(depart[5]), 1);
        cyc(8'h00, 8'h00, 1'b0);

        // 6: green glitch restarts startup loss, then reset mid-FLOW
        repeat (2) cyc(8'h40, 8'h00, 1'b0);
        repeat (4) cyc(8'h00, 8'h40, 1'b0);
        cyc(8'h00, 8'h00, 1'b0);
        repeat (6) cyc(8'h00, 8'h40, 1'b0);
        chk("glitch_e10", int'(lane[6]), 2);
        cyc(8'h00, 8'h40, 1'b0);
        chk("glitch_e11", int'(lane[6]), 1);
        chk("glitch_dep", int'(depart[6]), 1);
        repeat (2) cyc(8'h00, 8'h40, 1'b0);
        cyc(8'h00, 8'h40, 1'b1);
        chk("midrst_lane6", int'(lane[6]), 0);
        chk("midrst_ovf", int'(overflow), 0);
        chk("midrst_lane5", int'(lane[5]), 0);

        // Random traffic with slowly changing green patterns and rare resets
        begin
            logic [7:0] g;
            logic [7:0] a;
            logic       r;
            g = 8'h00;
            for (int k = 0; k < 4000; k++) begin
                if ($urandom_range(0, 11) == 0) g = 8'($urandom);
                a = 8'($urandom & $urandom & $urandom);
                r = ($urandom_range(0, 599) == 0);
                cyc(a, g, r);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
